// File: rtl/pc_fetch.sv
// Instruction fetch stage: PC register, IF/ID pipeline register and IDLE/RUN/DONE sequencer.
// Optional macro PC_BOUND_EN halts fetch once pc reaches MEM_DEPTH.
module pc_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] PC_STEP   = 32'd1,
  parameter int unsigned MEM_DEPTH = 40
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc,
  output logic        done,
  output logic [15:0] fetch_count
);

  // state | meaning
  // IDLE  | one post-reset cycle, no fetch
  // RUN   | fetching into IF/ID
  // DONE  | halted on memory bound, waits for redirect
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] pc, pc_nxt;
  logic        valid_nxt;
  logic [31:0] instr_nxt, idpc_nxt;
  logic        at_bound;
  logic        handshake;

`ifdef PC_BOUND_EN
  assign at_bound = (pc >= MEM_DEPTH);
  assign done     = (state == DONE);
`else
  assign at_bound = 1'b0;
  assign done     = 1'b0;
`endif

  assign imem_addr = pc;
  assign handshake = id_valid && id_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      id_valid <= 1'b0;
      id_instr <= 32'h0;
      id_pc    <= 32'h0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      id_valid <= valid_nxt;
      id_instr <= instr_nxt;
      id_pc    <= idpc_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    pc_nxt    = pc;
    valid_nxt = id_valid;
    instr_nxt = id_instr;
    idpc_nxt  = id_pc;
    case (state)
      IDLE: state_nxt = RUN;
      RUN: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
        end else if (!id_valid || id_ready) begin
          if (at_bound) begin
            // Out-of-range fetch: capture nothing, let IF/ID drain.
            state_nxt = DONE;
            valid_nxt = 1'b0;
          end else begin
            instr_nxt = imem_instr;
            idpc_nxt  = pc;
            valid_nxt = 1'b1;
            pc_nxt    = pc + PC_STEP;
          end
        end
      end
      DONE: begin
        if (redirect_valid) begin
          state_nxt = RUN;
          pc_nxt    = redirect_pc;
          valid_nxt = 1'b0;
        end else if (id_ready) begin
          valid_nxt = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      fetch_count <= 16'h0;
    else if (handshake && fetch_count != 16'hFFFF)
      fetch_count <= fetch_count + 16'd1;
  end

endmodule

// File: tb/tb_pc_fetch.sv
// Directed bench for pc_fetch: stimulus pushes expected IF/ID handshakes into a queue,
// a negedge monitor pops and compares them; direct checks cover reset, stall and redirect.
module tb_pc_fetch;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] imem_addr;
  logic [31:0] imem_instr;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;
  logic        done;
  logic [15:0] fetch_count;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q[$];

  pc_fetch dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_valid(id_valid), .id_ready(id_ready), .id_instr(id_instr), .id_pc(id_pc),
    .done(done), .fetch_count(fetch_count)
  );

  always #5 clk = ~clk;

  // Instruction memory: mem[i] = 32'h1000_0000 + i
  assign imem_instr = 32'h1000_0000 + imem_addr;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) exp_q.push_back(32'(i));
  endtask

  always @(negedge clk) begin
    if (rst_n && id_valid && id_ready) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_handshake", id_pc, 32'hFFFF_FFFF);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        chk("sb_id_pc", id_pc, e);
        chk("sb_id_instr", id_instr, 32'h1000_0000 + e);
      end
    end
  end

  initial begin
    rst_n = 1'b0;
    id_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    #3;
    chk("rst_id_valid", {31'h0, id_valid}, 32'h0);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_fetch_count", {16'h0, fetch_count}, 32'h0);
    chk("rst_done", {31'h0, done}, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    chk("rst_id_instr", id_instr, 32'h0);

    push_range(0, 7);
    step();
    rst_n = 1'b1;
    step();
    chk("idle_no_fetch_valid", {31'h0, id_valid}, 32'h0);
    chk("idle_no_fetch_addr", imem_addr, 32'h0);
    step();
    chk("first_valid", {31'h0, id_valid}, 32'h1);
    chk("first_id_pc", id_pc, 32'h0);
    chk("first_id_instr", id_instr, 32'h1000_0000);
    step(); chk("b2b_pc1", id_pc, 32'd1);
    step(); chk("b2b_pc2", id_pc, 32'd2);
    step(); chk("b2b_pc3", id_pc, 32'd3);
    step(); step();
    chk("pre_stall_pc", id_pc, 32'd5);
    id_ready = 1'b0;
    chk("pre_stall_count", {16'h0, fetch_count}, 32'd5);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("stall_id_pc", id_pc, 32'd5);
      chk("stall_id_instr", id_instr, 32'h1000_0005);
      chk("stall_addr", imem_addr, 32'd6);
      chk("stall_count", {16'h0, fetch_count}, 32'd5);
      chk("stall_valid", {31'h0, id_valid}, 32'h1);
    end
    id_ready = 1'b1;
    step(); chk("resume_pc6", id_pc, 32'd6);
    step(); chk("pre_redirect_pc7", id_pc, 32'd7);

    // Redirect together with an accepted handshake
    push_range(20, 22);
    redirect_valid = 1'b1;
    redirect_pc = 32'd20;
    step();
    chk("redir_flush_valid", {31'h0, id_valid}, 32'h0);
    chk("redir_addr", imem_addr, 32'd20);
    chk("redir_count", {16'h0, fetch_count}, 32'd8);
    redirect_valid = 1'b0;
    step();
    chk("redir_target_pc", id_pc, 32'd20);
    chk("redir_target_valid", {31'h0, id_valid}, 32'h1);
    step(); step();
    chk("pc22", id_pc, 32'd22);

    redirect_valid = 1'b1;
    redirect_pc = 32'd11;
    step();
    redirect_valid = 1'b0;
    step();
    chk("pre_reset_id_pc", id_pc, 32'd11);
    chk("pre_reset_addr", imem_addr, 32'd12);

    // Asynchronous reset between edges
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", {31'h0, id_valid}, 32'h0);
    chk("async_rst_addr", imem_addr, 32'h0);
    chk("async_rst_count", {16'h0, fetch_count}, 32'h0);
    chk("async_rst_id_pc", id_pc, 32'h0);
    chk("async_rst_id_instr", id_instr, 32'h0);
    chk("queue_drained_1", 32'(exp_q.size()), 32'd0);

    push_range(0, 1);
    step();
    rst_n = 1'b1;
    step();
    step(); chk("restart_pc0", id_pc, 32'd0);
    step(); chk("restart_pc1", id_pc, 32'd1);
    step(); chk("restart_pc2", id_pc, 32'd2);
    id_ready = 1'b0;
    chk("restart_count", {16'h0, fetch_count}, 32'd2);
    chk("done_low", {31'h0, done}, 32'h0);

`ifdef PC_BOUND_EN
    begin
      int n;
      rst_n = 1'b0;
      id_ready = 1'b1;
      #2;
      exp_q.delete();
      push_range(0, 39);
      step();
      rst_n = 1'b1;
      n = 0;
      while (!done && n < 60) begin
        step();
        n++;
      end
      chk("bound_reached", {31'h0, done}, 32'h1);
      chk("bound_cycles", 32'(n), 32'd42);
      chk("bound_valid", {31'h0, id_valid}, 32'h0);
      chk("bound_addr", imem_addr, 32'd40);
      chk("bound_count", {16'h0, fetch_count}, 32'd40);
      chk("bound_last_id_pc", id_pc, 32'd39);
      step();
      chk("bound_hold_addr", imem_addr, 32'd40);
      exp_q.push_back(32'd2);
      redirect_valid = 1'b1;
      redirect_pc = 32'd2;
      step();
      redirect_valid = 1'b0;
      chk("bound_done_clear", {31'h0, done}, 32'h0);
      step();
      chk("bound_redir_pc", id_pc, 32'd2);
      chk("bound_redir_valid", {31'h0, id_valid}, 32'h1);
      step();
      id_ready = 1'b0;
    end
`endif

    step();
    chk("queue_drained_end", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
